// File: rtl/rc4_decrypt.sv
// RC4 PRGA stage: walks the KSA-shuffled S memory, XORs keystream with the ROM and writes plaintext.
// Latency: 11 cycles per byte, complete pulses in cycle 11*MSG_LEN+1 after the start edge.
// Backpressure: none; start is sampled only in IDLE and ignored for the rest of a run.
module rc4_decrypt #(
  parameter int MSG_LEN = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       complete,
  output logic       bad_char,
  output logic [7:0] s_address,
  output logic [7:0] s_data,
  output logic       s_wren,
  input  logic [7:0] s_q,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_q,
  output logic [4:0] out_address,
  output logic [7:0] out_data,
  output logic       out_wren
);

  localparam logic [4:0] LAST_K = 5'(MSG_LEN - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_ADDR_I,
    ST_READ_I,
    ST_CALC_J,
    ST_ADDR_J,
    ST_READ_J,
    ST_SWAP_I,
    ST_SWAP_J,
    ST_ADDR_F,
    ST_READ_F,
    ST_WRITE_OUT,
    ST_FINISH
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [4:0] r_k;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] r_f;
  logic [7:0] r_enc;
  logic       r_bad;

  logic [7:0] w_plain;
  logic [7:0] w_fidx;
  logic       w_legal;

  assign w_plain = r_f ^ r_enc;
  // Since the swap only exchanges S[i] and S[j], si+sj still points at the keystream byte.
  assign w_fidx  = r_si + r_sj;
  // Accepted message alphabet: lowercase letters and space.
  assign w_legal = ((w_plain >= 8'h61) && (w_plain <= 8'h7A)) || (w_plain == 8'h20);

  assign rom_address = r_k;
  assign out_address = r_k;
  assign bad_char    = r_bad;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state sequencing and memory-port decode.
  always_comb begin
    w_next    = r_state;
    s_address = 8'h00;
    s_data    = 8'h00;
    s_wren    = 1'b0;
    out_data  = 8'h00;
    out_wren  = 1'b0;
    complete  = 1'b0;
    case (r_state)
      ST_IDLE:   if (start) w_next = ST_INC_I;
      ST_INC_I:  w_next = ST_ADDR_I;
      ST_ADDR_I: begin
        s_address = r_i;
        w_next    = ST_READ_I;
      end
      ST_READ_I: begin
        s_address = r_i;
        w_next    = ST_CALC_J;
      end
      ST_CALC_J: w_next = ST_ADDR_J;
      ST_ADDR_J: begin
        s_address = r_j;
        w_next    = ST_READ_J;
      end
      ST_READ_J: begin
        s_address = r_j;
        w_next    = ST_SWAP_I;
      end
      ST_SWAP_I: begin
        s_address = r_i;
        s_data    = r_sj;
        s_wren    = 1'b1;
        w_next    = ST_SWAP_J;
      end
      ST_SWAP_J: begin
        s_address = r_j;
        s_data    = r_si;
        s_wren    = 1'b1;
        w_next    = ST_ADDR_F;
      end
      ST_ADDR_F: begin
        s_address = w_fidx;
        w_next    = ST_READ_F;
      end
      ST_READ_F: begin
        s_address = w_fidx;
        w_next    = ST_WRITE_OUT;
      end
      ST_WRITE_OUT: begin
        out_data = w_plain;
        out_wren = 1'b1;
        w_next   = (r_k == LAST_K) ? ST_FINISH : ST_INC_I;
      end
      ST_FINISH: begin
        complete = 1'b1;
        w_next   = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath registers: indices, captured S/ROM bytes and the sticky bad-character flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_i   <= 8'h00;
      r_j   <= 8'h00;
      r_k   <= 5'd0;
      r_si  <= 8'h00;
      r_sj  <= 8'h00;
      r_f   <= 8'h00;
      r_enc <= 8'h00;
      r_bad <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:   if (start) r_bad <= 1'b0;
        ST_INC_I:  r_i <= r_i + 8'd1;
        ST_READ_I: r_si <= s_q;
        ST_CALC_J: r_j <= r_j + r_si;
        ST_READ_J: r_sj <= s_q;
        ST_READ_F: begin
          r_f   <= s_q;
          r_enc <= rom_q;
        end
        ST_WRITE_OUT: begin
          if (!w_legal) r_bad <= 1'b1;
          if (r_k != LAST_K) r_k <= r_k + 5'd1;
        end
        ST_FINISH: begin
          r_i <= 8'h00;
          r_j <= 8'h00;
          r_k <= 5'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rc4_decrypt.md
# rc4_decrypt

Downstream stage of the RC4 key-search datapath: once the key-scheduling shuffle has permuted the S memory for the current 24-bit key, this block runs the RC4 pseudo-random generation algorithm (PRGA) over S. It XORs each keystream byte with the encrypted-message ROM and writes the plaintext to the decrypted-message RAM. It also reports whether every output byte is a legal message character, so the key-search controller can accept or reject the key.

## Interface
Parameters:
- MSG_LEN, 32: number of message bytes processed, 1..32.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin decryption; sampled only in IDLE.
- complete  output  1  one-cycle pulse when all MSG_LEN bytes are written.
- bad_char  output  1  sticky flag: at least one output byte was not 0x61..0x7A or 0x20. Valid when complete pulses.
- s_address  output  8  S memory address.
- s_data  output  8  S memory write data.
- s_wren  output  1  S memory write enable.
- s_q  input  8  S memory read data.
- rom_address  output  5  encrypted-message ROM address, equal to k.
- rom_q  input  8  encrypted byte.
- out_address  output  5  decrypted RAM address, equal to k.
- out_data  output  8  decrypted byte.
- out_wren  output  1  decrypted RAM write enable.

## Operation
- Internal registers:
  - i and j: 8 bits.
  - k: 5 bits, the byte index.
  - si, sj, f, enc: 8 bits each.
- All 8-bit arithmetic is modulo 256 and carries are dropped.
- States, with one cycle each:
  - IDLE
  - INC_I: i <= i+1.
  - ADDR_I, then READ_I: si <= s_q.
  - CALC_J: j <= j+si.
  - ADDR_J, then READ_J: sj <= s_q.
  - SWAP_I: write sj to S[i].
  - SWAP_J: write si to S[j].
  - ADDR_F, then READ_F: f <= s_q and enc <= rom_q.
  - WRITE_OUT
  - FINISH
- Transitions:
  - IDLE goes to INC_I when start is high.
  - From INC_I to READ_F, each state advances to the next state in the list.
  - WRITE_OUT goes to FINISH when k == MSG_LEN-1; otherwise it sets k <= k+1 and goes to INC_I.
  - FINISH goes to IDLE.
- s_address is driven as follows:
  - i in ADDR_I, READ_I and SWAP_I.
  - j in ADDR_J, READ_J and SWAP_J.
  - si+sj in ADDR_F and READ_F.
  - 0 otherwise.
- s_wren is high only in SWAP_I and SWAP_J. s_data is sj in SWAP_I, si in SWAP_J, and 0 otherwise.
- When i == j, both swap writes hit the same address with the same value. This is legal and needs no special case.
- In WRITE_OUT: out_wren=1, out_address=k, out_data=f^enc.
- bad_char is set in WRITE_OUT if f^enc is outside 0x61..0x7A and is not 0x20. It is cleared on the start acceptance edge and on reset.
- In FINISH: complete=1. i, j and k are cleared to 0.
- start is ignored outside IDLE, so there are no restarts mid-run.
- Reset at any time, including mid-operation, takes effect on the next clk edge:
  - The state becomes IDLE.
  - i, j, k, si, sj, f, enc and bad_char become 0.
  - No further writes are issued.
  - A partially written output RAM is left as-is.

## Timing
- Reset values: complete=0, bad_char=0, s_wren=0, out_wren=0, s_address=0, s_data=0, out_address=0, out_data=0, rom_address=0.
- Memory read latency: the address is driven for two cycles (ADDR_x, READ_x), and read data is captured at the edge ending READ_x.
- rom_address equals k throughout, so rom_q is stable by READ_F.
- Per-byte cost is 11 cycles. Let start be sampled high in IDLE at edge 0:
  - Byte k occupies cycles 11k+1 .. 11k+11.
  - Its out_wren is high in cycle 11k+11.
  - complete is high in cycle 11*MSG_LEN+1.
  - The block is back in IDLE in cycle 11*MSG_LEN+2.
- start may be asserted in the same cycle complete is high. It is taken in the following IDLE cycle.

## Test plan
- Identity S (S[x]=x), MSG_LEN=2, ROM={0x63,0x64}:
  - The first out write is addr 0, data 0x61.
  - The second is addr 1, data 0x61, after S[2]=3 and S[3]=2.
  - bad_char=0.
- S preloaded with the KSA result for key 0x4B6579, MSG_LEN=9, ROM=BB F3 16 E8 D9 40 AF 0A D3:
  - Output is "Plaintext" (0x50 6C 61 69 6E 74 65 78 74).
  - bad_char=1, because 0x50 is uppercase.
- Same S, ROM all zero, MSG_LEN=4:
  - Output is EB 9F 77 81 (the raw keystream).
  - bad_char=1.
- Timing, MSG_LEN=32:
  - complete is high for exactly one cycle, at cycle 353 after the start edge.
  - Exactly 32 out_wren pulses are spaced 11 cycles apart.
  - Exactly 64 s_wren pulses occur.
- Assert reset at cycle 50 of a run:
  - The next cycle shows IDLE, with all outputs 0 and bad_char=0.
  - A fresh start reproduces the full correct output.
- Pulse start in cycles 5 and 200 of a run: both are ignored, and the run finishes at cycle 353 with unchanged results.
